// File: rtl/fanout_bcast_buf.sv
// Two-entry broadcast buffer: each accepted word is offered to NUM_OUT sinks and
// popped once every sink has taken it; bcast_cnt counts completed broadcasts.
module fanout_bcast_buf #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 8
) (
    input  logic               iccad_clk,
    input  logic               iccad_rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [15:0]        bcast_cnt
);

    logic               rst_sync_q, rst_sync_d;
    logic [1:0]         count_q, count_d;
    logic [NUM_OUT-1:0] done_q, done_d;
    logic [15:0]        bcast_cnt_q, bcast_cnt_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic [NUM_OUT-1:0] hs;
    logic               push;
    logic               pop;

    // Reset asserts asynchronously; its release is retimed so every flop leaves reset together.
    assign rst_sync_d = 1'b0;

    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            rst_sync_q <= 1'b1;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign in_ready  = !rst_sync_q && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0) ? ~done_q : '0;
    assign out_data  = (count_q != 2'd0) ? head_q : '0;
    assign bcast_cnt = bcast_cnt_q;

    always_comb begin
        hs          = out_valid & out_ready;
        push        = in_valid && in_ready;
        pop         = (count_q != 2'd0) && (&(done_q | hs));
        done_d      = done_q | hs;
        bcast_cnt_d = bcast_cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            done_d      = '0;
            bcast_cnt_d = bcast_cnt_q + 16'd1;
            // A push alongside a pop only happens at count 1, so the new word goes straight to head.
            head_d      = push ? in_data : tail_q;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
        end
    end

    always_ff @(posedge iccad_clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            count_q     <= 2'd0;
            done_q      <= '0;
            bcast_cnt_q <= 16'd0;
        end else begin
            count_q     <= count_d;
            done_q      <= done_d;
            bcast_cnt_q <= bcast_cnt_d;
        end
    end

    // Payload storage is qualified by count, so it needs no reset.
    always_ff @(posedge iccad_clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

endmodule
